// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_arb_pkg
// Purpose  : Shared types and constants for the 2-requester internal bus
//            arbiter (state encoding, bus width, hold counter width).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

  // Encoding chosen so that bit 0 is "source 0 owns" and bit 1 is
  // "source 1 owns": the grants come straight off the state flops.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_e;

  localparam int BUS_W  = 8;
  localparam int HOLD_W = 4;

endpackage : bus_arb_pkg
`default_nettype wire

// File: rtl/mux8b2x1.sv
`default_nettype none
// ============================================================================
// Module   : mux8b2x1
// Purpose  : 2:1 data multiplexer for the internal bus (combinational).
// Ports    : sel_i  - select, 1 = d1_i, 0 = d0_i
//            d0_i   - data input 0
//            d1_i   - data input 1
//            y_o    - selected data
// Revision : 1.0 - initial release
// ============================================================================
module mux8b2x1 #(
  parameter int W = 8
) (
  input  logic         sel_i,
  input  logic [W-1:0] d0_i,
  input  logic [W-1:0] d1_i,
  output logic [W-1:0] y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule : mux8b2x1
`default_nettype wire

// File: rtl/bus_arb2x1.sv
`default_nettype none
// ============================================================================
// Module   : bus_arb2x1
// Purpose  : Two-requester round-robin arbiter with bounded hold time and a
//            registered output stage for the shared 8-bit internal bus.
// Ports    : clk_i        - rising-edge clock
//            rst_n_i      - asynchronous active-low reset
//            req0_i/req1_i- bus requests (held while ownership is wanted)
//            din0_i/din1_i- source data bytes
//            gnt0_o/gnt1_o- registered grants (never both high)
//            sel_o        - mux select, equal to gnt1_o
//            bus_out_o    - registered bus byte
//            bus_valid_o  - bus_out_o was captured from the owner this cycle
// Revision : 1.0 - initial release
// ============================================================================
module bus_arb2x1
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4  // legal range 1..15
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic [BUS_W-1:0] din0_i,
  input  logic [BUS_W-1:0] din1_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic             sel_o,
  output logic [BUS_W-1:0] bus_out_o,
  output logic             bus_valid_o
);

  localparam logic [HOLD_W-1:0] C_HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] C_HOLD_ONE = HOLD_W'(1);

  state_e            state_q, state_d;
  logic              last_q, last_d;        // most recent owner
  logic [HOLD_W-1:0] hold_q, hold_d;        // cycles owned in this tenure
  logic [BUS_W-1:0]  bus_out_q, bus_out_d;
  logic              bus_valid_q, bus_valid_d;

  logic              w_sel;
  logic [BUS_W-1:0]  w_mux_data;
  logic              w_owner;               // 1 when source 1 owns
  logic              w_own_req;
  logic              w_oth_req;
  logic              w_hold_max;
  state_e            w_other_st;

  assign w_sel = state_q[1];

  mux8b2x1 #(.W(BUS_W)) u_mux (
    .sel_i (w_sel),
    .d0_i  (din0_i),
    .d1_i  (din1_i),
    .y_o   (w_mux_data)
  );

  // Requests seen from the owner's point of view so both OWN states share
  // one block of transition logic.
  assign w_owner    = state_q[1];
  assign w_own_req  = w_owner ? req1_i : req0_i;
  assign w_oth_req  = w_owner ? req0_i : req1_i;
  assign w_hold_max = (hold_q == C_HOLD_MAX);
  assign w_other_st = w_owner ? ST_OWN0 : ST_OWN1;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    hold_d      = hold_q;
    bus_out_d   = bus_out_q;
    bus_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0_i || req1_i) begin
          hold_d = C_HOLD_ONE;
          if (req0_i && req1_i) begin
            // Tie goes to whoever did not own the bus last.
            state_d = last_q ? ST_OWN0 : ST_OWN1;
          end else begin
            state_d = req0_i ? ST_OWN0 : ST_OWN1;
          end
        end
      end

      ST_OWN0, ST_OWN1: begin
        // The owner's byte is captured on every edge it still requests,
        // including the edge at which it gets preempted.
        if (w_own_req) begin
          bus_out_d   = w_mux_data;
          bus_valid_d = 1'b1;
        end

        if (!w_own_req) begin
          last_d = w_owner;
          if (w_oth_req) begin
            state_d = w_other_st;
            hold_d  = C_HOLD_ONE;
          end else begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end
        end else if (w_oth_req && w_hold_max) begin
          state_d = w_other_st;
          hold_d  = C_HOLD_ONE;
          last_d  = w_owner;
        end else if (!w_hold_max) begin
          hold_d = hold_q + C_HOLD_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;   // source 0 wins the first tie
      hold_q      <= '0;
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
    end
  end

  assign gnt0_o      = state_q[0];
  assign gnt1_o      = state_q[1];
  assign sel_o       = state_q[1];
  assign bus_out_o   = bus_out_q;
  assign bus_valid_o = bus_valid_q;

endmodule : bus_arb2x1
`default_nettype wire

// File: tb/tb_bus_arb2x1.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arb2x1
// Purpose  : Self-checking bench for bus_arb2x1. Two instances (MAX_HOLD=4
//            and MAX_HOLD=1) share stimulus; each is compared every cycle
//            against a behavioural model of ownership/tenure rules.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arb2x1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] din0, din1;

  logic       g0_4, g1_4, sel_4, bv_4;
  logic [7:0] bo_4;
  logic       g0_1, g1_1, sel_1, bv_1;
  logic [7:0] bo_1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arb2x1 #(.MAX_HOLD(4)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .req0_i(req0), .req1_i(req1),
    .din0_i(din0), .din1_i(din1), .gnt0_o(g0_4), .gnt1_o(g1_4),
    .sel_o(sel_4), .bus_out_o(bo_4), .bus_valid_o(bv_4)
  );

  bus_arb2x1 #(.MAX_HOLD(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .req0_i(req0), .req1_i(req1),
    .din0_i(din0), .din1_i(din1), .gnt0_o(g0_1), .gnt1_o(g1_1),
    .sel_o(sel_1), .bus_out_o(bo_1), .bus_valid_o(bv_1)
  );

  // Model: owner is -1 (nobody), 0 or 1.
  typedef struct {
    int         own;
    int         last;
    int         hold;
    logic [7:0] bout;
    logic       bvalid;
  } mdl_t;

  mdl_t m4, m1;

  function automatic mdl_t mdl_rst();
    mdl_t n;
    n.own = -1; n.last = 1; n.hold = 0; n.bout = 8'h00; n.bvalid = 1'b0;
    return n;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int maxh, logic r0, logic r1,
                                    logic [7:0] d0, logic [7:0] d1);
    mdl_t n;
    int   x, y;
    int   r[2];
    n    = m;
    r[0] = int'(r0);
    r[1] = int'(r1);
    n.bvalid = 1'b0;
    if (m.own < 0) begin
      if (r[0] == 1 && r[1] == 1) n.own = 1 - m.last;
      else if (r[0] == 1)         n.own = 0;
      else if (r[1] == 1)         n.own = 1;
      if (n.own >= 0) n.hold = 1;
    end else begin
      x = m.own;
      y = 1 - x;
      if (r[x] == 1) begin
        n.bout   = (x == 1) ? d1 : d0;
        n.bvalid = 1'b1;
      end
      if (r[x] == 0) begin
        n.last = x;
        if (r[y] == 1) begin n.own = y;  n.hold = 1; end
        else           begin n.own = -1; n.hold = 0; end
      end else if (r[y] == 1 && m.hold == maxh) begin
        n.own = y; n.hold = 1; n.last = x;
      end else begin
        n.hold = (m.hold + 1 > maxh) ? maxh : m.hold + 1;
      end
    end
    return n;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, "_gnt0_h4"}, {7'd0, g0_4}, {7'd0, m4.own == 0});
    chk({tag, "_gnt1_h4"}, {7'd0, g1_4}, {7'd0, m4.own == 1});
    chk({tag, "_sel_h4"},  {7'd0, sel_4}, {7'd0, m4.own == 1});
    chk({tag, "_bus_h4"},  bo_4, m4.bout);
    chk({tag, "_vld_h4"},  {7'd0, bv_4}, {7'd0, m4.bvalid});
    chk({tag, "_excl_h4"}, {7'd0, g0_4 & g1_4}, 8'h00);
    chk({tag, "_gnt0_h1"}, {7'd0, g0_1}, {7'd0, m1.own == 0});
    chk({tag, "_gnt1_h1"}, {7'd0, g1_1}, {7'd0, m1.own == 1});
    chk({tag, "_sel_h1"},  {7'd0, sel_1}, {7'd0, m1.own == 1});
    chk({tag, "_bus_h1"},  bo_1, m1.bout);
    chk({tag, "_vld_h1"},  {7'd0, bv_1}, {7'd0, m1.bvalid});
    chk({tag, "_excl_h1"}, {7'd0, g0_1 & g1_1}, 8'h00);
  endtask

  // Drive inputs away from the edge, advance one edge, update model, compare.
  task automatic step(logic r0, logic r1, logic [7:0] d0, logic [7:0] d1,
                      string tag);
    req0 = r0; req1 = r1; din0 = d0; din1 = d1;
    @(posedge clk);
    m4 = mdl_step(m4, 4, r0, r1, d0, d1);
    m1 = mdl_step(m1, 1, r0, r1, d0, d1);
    #1 chk_all(tag);
  endtask

  // Assert reset between edges and check it takes effect without a clock.
  task automatic async_reset(string tag);
    #2 rst_n = 1'b0;
    #1;
    m4 = mdl_rst();
    m1 = mdl_rst();
    chk_all(tag);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    logic prev_g0_1;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; din0 = 8'h00; din1 = 8'h00;
    m4 = mdl_rst();
    m1 = mdl_rst();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk_all("reset");

    // Single requester 0
    step(1'b1, 1'b0, 8'hA5, 8'h00, "s1_e1");
    chk("s1_gnt0_direct", {7'd0, g0_4}, 8'h01);
    step(1'b1, 1'b0, 8'hA5, 8'h00, "s1_e2");
    chk("s1_bus_direct", bo_4, 8'hA5);
    chk("s1_vld_direct", {7'd0, bv_4}, 8'h01);
    chk("s1_sel_direct", {7'd0, sel_4}, 8'h00);

    // Simultaneous requests from reset
    async_reset("s2_rst");
    prev_g0_1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 8'h11, 8'h22, "s2");
      if (i == 3) chk("s2_own0_4th", {7'd0, g0_4}, 8'h01);
      if (i == 4) begin
        chk("s2_handover", {7'd0, g1_4}, 8'h01);
        chk("s2_last_byte0", bo_4, 8'h11);
      end
      if (i == 5) chk("s2_first_byte1", bo_4, 8'h22);
      if (i > 0) chk("s2_alt_h1", {7'd0, g0_1}, {7'd0, ~prev_g0_1});
      prev_g0_1 = g0_1;
    end

    // Owner 1 releases while 0 waits: direct hand-over
    step(1'b1, 1'b0, 8'h33, 8'h44, "s3_rel");
    chk("s3_gnt0", {7'd0, g0_4}, 8'h01);
    chk("s3_gnt1", {7'd0, g1_4}, 8'h00);
    chk("s3_gap",  {7'd0, bv_4}, 8'h00);
    step(1'b1, 1'b0, 8'h33, 8'h44, "s3_next");
    chk("s3_vld", {7'd0, bv_4}, 8'h01);

    // Invisible glitch, then long single tenure by source 1
    async_reset("s4_rst");
    req1 = 1'b1;
    #2 req1 = 1'b0;
    step(1'b0, 1'b0, 8'h00, 8'h00, "s4_glitch");
    chk("s4_glitch_gnt1", {7'd0, g1_4}, 8'h00);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 8'h00, 8'(i), "s4_hold");
      chk("s4_gnt1_held", {7'd0, g1_4}, 8'h01);
    end
    step(1'b1, 1'b1, 8'h55, 8'h66, "s4_pre");
    chk("s4_preempt", {7'd0, g0_4}, 8'h01);

    // Reset mid-tenure in OWN1
    async_reset("s5_rst0");
    step(1'b0, 1'b1, 8'h00, 8'h3C, "s5_a");
    step(1'b0, 1'b1, 8'h00, 8'h3C, "s5_b");
    chk("s5_bus_3c", bo_4, 8'h3C);
    async_reset("s5_rst1");
    chk("s5_bus_clr", bo_4, 8'h00);
    chk("s5_gnt1_clr", {7'd0, g1_4}, 8'h00);
    step(1'b1, 1'b1, 8'h77, 8'h88, "s5_tie");
    chk("s5_tie_src0", {7'd0, g0_4}, 8'h01);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step(1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0),
             8'($urandom), 8'($urandom), "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bus_arb2x1
`default_nettype wire
